pll_lock_monitor: RTL
=====================

# pll_lock_monitor

Lock-side controller for the DDR2 rPLL: drives the PLL's active-high reset, watches its lock output, and releases the DDR2 subsystem reset only after lock has been stable for a programmable time. Runs on the free-running board reference clock (25 MHz), never on a PLL output. On lock loss it re-asserts the subsystem reset and, if lock does not recover, re-pulses the PLL reset up to a bounded number of retries before flagging failure.

## Interface
- RST_CYCLES, 16: cycles `pll_reset` is held high per reset pulse (≥1).
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before release (≥2).
- TIMEOUT_CYCLES, 65536: cycles allowed in WAIT_LOCK before a retry (> STABLE_CYCLES).
- MAX_RETRIES, 7: PLL reset re-pulses allowed before FAIL (1..15).

- clkin  in  1  reference clock, free-running; the block's only clock.
- reset_n  in  1  asynchronous, active-low block reset.
- pll_lock  in  1  PLL lock, asynchronous to clkin; synchronized internally.
- relock_req  in  1  single-cycle request to force a fresh PLL reset sequence.
- pll_reset  out  1  to PLL reset pin, active high.
- ddr_reset_n  out  1  DDR2 subsystem reset, active low, registered.
- ready  out  1  high while in RUN.
- fail  out  1  high while in FAIL.
- retry_cnt  out  4  PLL reset pulses issued since last successful RUN entry, saturating at 15.

## Operation
- pll_lock passes through a 2-flop synchronizer (reset value 0); all logic uses the synchronized value `lock_s`.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL. Reset state PLL_RST with counter 0.
- PLL_RST: pll_reset=1; count RST_CYCLES cycles, then -> WAIT_LOCK, counter cleared.
- WAIT_LOCK: pll_reset=0; if lock_s=1 -> STABLE (counter cleared); else if counter reaches TIMEOUT_CYCLES-1: if retry_cnt < MAX_RETRIES -> PLL_RST with retry_cnt+1, else -> FAIL.
- STABLE: if lock_s=0 -> WAIT_LOCK (counter cleared, timeout restarts); if lock_s held for STABLE_CYCLES cycles -> RUN, retry_cnt cleared.
- RUN: ddr_reset_n=1, ready=1; lock_s=0 -> WAIT_LOCK (single-cycle glitch counts as loss).
- FAIL: pll_reset=0, ddr_reset_n=0, fail=1; exits only via relock_req or reset_n.
- relock_req=1 in any state -> PLL_RST, counter cleared, retry_cnt cleared; takes priority over every other transition in the same cycle.
- ddr_reset_n=0 in every state except RUN.
- One shared counter sized for max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES); cleared on every state change.

## Timing
- Reset values (reset_n low, async): state PLL_RST, pll_reset=1, ddr_reset_n=0, ready=0, fail=0, retry_cnt=0, synchronizer 0.
- All outputs registered; they reflect the state they describe on the same cycle the state register changes.
- pll_reset high for exactly RST_CYCLES clkin cycles per pulse.
- pll_lock rise to ddr_reset_n rise: 2 (sync) + STABLE_CYCLES + 1 cycles, provided lock stays high.
- pll_lock fall in RUN to ddr_reset_n fall: 3 cycles (2 sync + 1 register).
- relock_req to pll_reset=1: next cycle.
- reset_n deassertion: first PLL_RST count begins on the first clkin edge after release; reset_n deassertion itself is synchronized externally.

## Structure
- Shared package `pll_ctrl_pkg`: state enum, counter-width function (clog2 of max of the three cycle parameters), retry-counter width constant (4).
- Sub-module `sync_2ff` (2-flop synchronizer, async active-low reset, reset value parameter) instantiated for pll_lock; reused elsewhere for other async status bits.

## Test plan
Bench parameters: RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Power-up, pll_lock rises 10 cycles after pll_reset falls and stays -> pll_reset high exactly 4 cycles; ddr_reset_n rises 11 cycles after pll_lock; ready=1, retry_cnt=0.
- pll_lock glitches low 1 cycle at cycle 5 of STABLE -> back to WAIT_LOCK; ddr_reset_n stays 0; release only after a fresh 8-cycle stable window.
- pll_lock drops in RUN -> ddr_reset_n=0 and ready=0 3 cycles later; relock within 32 cycles -> RUN without a pll_reset pulse.
- pll_lock never rises -> exactly 3 pll_reset pulses of 4 cycles (retry_cnt 0,1,2), then fail=1, pll_reset=0, ddr_reset_n=0 held indefinitely.
- In FAIL, relock_req pulse, lock arrives -> pll_reset next cycle, retry_cnt=0, fail=0, eventually RUN.
- reset_n asserted mid-STABLE -> all outputs at reset values immediately (asynchronously), sequence restarts from PLL_RST on release.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock controller: state encoding,
// output bundle per state, and counter sizing.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } pll_state_e;

   localparam int RETRY_W = 4;

   typedef struct packed {
      logic pll_reset;
      logic ddr_reset_n;
      logic ready;
      logic fail;
   } pll_outs_t;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return $clog2(m);
   endfunction

   // Unknown encodings hold the PLL in reset and keep DDR2 in reset.
   function automatic pll_outs_t state_outs(input pll_state_e s);
      pll_outs_t o;
      o = '{pll_reset: 1'b0, ddr_reset_n: 1'b0, ready: 1'b0, fail: 1'b0};
      case (s)
         ST_PLL_RST:   o.pll_reset = 1'b1;
         ST_WAIT_LOCK: o.pll_reset = 1'b0;
         ST_STABLE:    o.pll_reset = 1'b0;
         ST_RUN: begin
            o.ddr_reset_n = 1'b1;
            o.ready       = 1'b1;
         end
         ST_FAIL:      o.fail = 1'b1;
         default:      o.pll_reset = 1'b1;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous status bit, with a
// configurable reset value.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;

   // Two-stage capture of the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= RST_VAL;
         q      <= RST_VAL;
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/pll_lock_monitor.sv
// Lock-side controller for the DDR2 PLL: pulses the PLL reset, qualifies lock
// over a stable window, and gates the DDR2 subsystem reset with bounded retries.
module pll_lock_monitor
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES    = 7
) (
   input  logic       clkin,
   input  logic       reset_n,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       ddr_reset_n,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt
);

   localparam int CW = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] TMO_LAST    = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);
   localparam logic [RETRY_W-1:0] RETRY_SAT = {RETRY_W{1'b1}};
   localparam logic [RETRY_W-1:0] RETRY_ONE = RETRY_W'(1);

   pll_state_e         state_r;
   logic [CW-1:0]      cnt_r;
   logic [RETRY_W-1:0] retry_r;
   pll_outs_t          outs_r;
   logic               lock_s;

   sync_2ff #(.RST_VAL(1'b0)) u_lock_sync (
      .clk   (clkin),
      .rst_n (reset_n),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Single-block FSM: state, shared counter, retry count and outputs change together.
   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_PLL_RST;
         cnt_r   <= CNT_ZERO;
         retry_r <= {RETRY_W{1'b0}};
         outs_r  <= state_outs(ST_PLL_RST);
      end else if (relock_req) begin
         state_r <= ST_PLL_RST;
         cnt_r   <= CNT_ZERO;
         retry_r <= {RETRY_W{1'b0}};
         outs_r  <= state_outs(ST_PLL_RST);
      end else begin
         case (state_r)
            ST_PLL_RST: begin
               if (cnt_r == RST_LAST) begin
                  state_r <= ST_WAIT_LOCK;
                  cnt_r   <= CNT_ZERO;
                  outs_r  <= state_outs(ST_WAIT_LOCK);
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_WAIT_LOCK: begin
               if (lock_s) begin
                  state_r <= ST_STABLE;
                  cnt_r   <= CNT_ZERO;
                  outs_r  <= state_outs(ST_STABLE);
               end else if (cnt_r == TMO_LAST) begin
                  cnt_r <= CNT_ZERO;
                  if (retry_r < RETRY_MAX) begin
                     state_r <= ST_PLL_RST;
                     retry_r <= (retry_r == RETRY_SAT) ? retry_r : retry_r + RETRY_ONE;
                     outs_r  <= state_outs(ST_PLL_RST);
                  end else begin
                     state_r <= ST_FAIL;
                     outs_r  <= state_outs(ST_FAIL);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_STABLE: begin
               if (!lock_s) begin
                  state_r <= ST_WAIT_LOCK;
                  cnt_r   <= CNT_ZERO;
                  outs_r  <= state_outs(ST_WAIT_LOCK);
               end else if (cnt_r == STABLE_LAST) begin
                  state_r <= ST_RUN;
                  cnt_r   <= CNT_ZERO;
                  retry_r <= {RETRY_W{1'b0}};
                  outs_r  <= state_outs(ST_RUN);
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            ST_RUN: begin
               if (!lock_s) begin
                  state_r <= ST_WAIT_LOCK;
                  cnt_r   <= CNT_ZERO;
                  outs_r  <= state_outs(ST_WAIT_LOCK);
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            ST_FAIL: begin
               cnt_r <= CNT_ZERO;
            end
            default: begin
               state_r <= ST_PLL_RST;
               cnt_r   <= CNT_ZERO;
               outs_r  <= state_outs(ST_PLL_RST);
            end
         endcase
      end
   end

   assign pll_reset   = outs_r.pll_reset;
   assign ddr_reset_n = outs_r.ddr_reset_n;
   assign ready       = outs_r.ready;
   assign fail        = outs_r.fail;
   assign retry_cnt   = retry_r;

endmodule
